// File: rtl/axi_read_responder.sv
// AXI-style read burst responder: serves incrementing, wrapping word bursts from an internal store loaded through a backdoor port.
// Define AXI_RESP_INIT_LATENCY_EN to insert LATENCY wait cycles between address accept and the first beat.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 26
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module axi_read_responder #(
    parameter int ADDR_WIDTH = `ADDR_WIDTH,
    parameter int DATA_WIDTH = `DATA_WIDTH,
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] ARADDR,
    input  logic [3:0]            ARLEN,
    input  logic [3:0]            ARID,
    input  logic                  ARVALID,
    output logic                  ARREADY,
    output logic [DATA_WIDTH-1:0] RDATA,
    output logic [3:0]            RID,
    output logic                  RLAST,
    output logic                  RVALID,
    input  logic                  RREADY,
    input  logic                  wr_en,
    input  logic [DEPTH_LOG2-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data
);

    typedef enum logic [1:0] {IDLE, WAIT, BURST} state_t;

`ifdef AXI_RESP_INIT_LATENCY_EN
    localparam bit LatencyEn = (LATENCY != 0);
    localparam int CntW      = (LATENCY > 1) ? $clog2(LATENCY + 1) : 1;
    logic [CntW-1:0] waitCnt_q;
`else
    // LATENCY has no effect when the wait stage is compiled out.
    localparam bit LatencyEn = 1'b0 && (LATENCY != 0);
`endif

    state_t                state_q;
    logic [DATA_WIDTH-1:0] mem [2**DEPTH_LOG2];
    logic [DEPTH_LOG2-1:0] wordIdx_q;
    logic [4:0]            beatsLeft_q;
    logic                  arReady_q;
    logic                  rValid_q;
    logic                  rLast_q;
    logic [3:0]            rId_q;
    logic [DATA_WIDTH-1:0] rData_q;

    logic                  arHandshake;
    logic [DEPTH_LOG2-1:0] startIdx;
    logic [4:0]            burstLen;
    logic                  unusedAddrBits;

    assign arHandshake    = ARVALID & arReady_q;
    assign startIdx       = ARADDR[DEPTH_LOG2+1:2];
    assign burstLen       = (ARLEN == 4'd0) ? 5'd16 : {1'b0, ARLEN};
    assign unusedAddrBits = ^{ARADDR[ADDR_WIDTH-1:DEPTH_LOG2+2], ARADDR[1:0]};

    assign ARREADY = arReady_q;
    assign RVALID  = rValid_q;
    assign RLAST   = rLast_q;
    assign RID     = rId_q;
    assign RDATA   = rData_q;

    // Backing store is deliberately outside the reset domain so contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // beatsLeft_q counts beats not yet loaded into the output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            arReady_q   <= 1'b0;
            rValid_q    <= 1'b0;
            rLast_q     <= 1'b0;
            rId_q       <= 4'd0;
            rData_q     <= '0;
            wordIdx_q   <= '0;
            beatsLeft_q <= 5'd0;
`ifdef AXI_RESP_INIT_LATENCY_EN
            waitCnt_q   <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (arHandshake) begin
                        arReady_q <= 1'b0;
                        rId_q     <= ARID;
                        if (LatencyEn) begin
                            state_q     <= WAIT;
                            wordIdx_q   <= startIdx;
                            beatsLeft_q <= burstLen;
`ifdef AXI_RESP_INIT_LATENCY_EN
                            waitCnt_q   <= CntW'(LATENCY);
`endif
                        end else begin
                            state_q     <= BURST;
                            rValid_q    <= 1'b1;
                            rData_q     <= mem[startIdx];
                            rLast_q     <= (burstLen == 5'd1);
                            wordIdx_q   <= startIdx + 1'b1;
                            beatsLeft_q <= burstLen - 5'd1;
                        end
                    end else begin
                        arReady_q <= 1'b1;
                    end
                end
                WAIT: begin
`ifdef AXI_RESP_INIT_LATENCY_EN
                    waitCnt_q <= waitCnt_q - 1'b1;
                    if (waitCnt_q == CntW'(1)) begin
                        state_q     <= BURST;
                        rValid_q    <= 1'b1;
                        rData_q     <= mem[wordIdx_q];
                        rLast_q     <= (beatsLeft_q == 5'd1);
                        wordIdx_q   <= wordIdx_q + 1'b1;
                        beatsLeft_q <= beatsLeft_q - 5'd1;
                    end
`else
                    state_q   <= IDLE;
                    arReady_q <= 1'b1;
`endif
                end
                BURST: begin
                    if (RREADY) begin
                        if (rLast_q) begin
                            state_q   <= IDLE;
                            rValid_q  <= 1'b0;
                            rLast_q   <= 1'b0;
                            arReady_q <= 1'b1;
                        end else begin
                            rData_q     <= mem[wordIdx_q];
                            rLast_q     <= (beatsLeft_q == 5'd1);
                            wordIdx_q   <= wordIdx_q + 1'b1;
                            beatsLeft_q <= beatsLeft_q - 5'd1;
                        end
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    arReady_q <= 1'b0;
                    rValid_q  <= 1'b0;
                    rLast_q   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_read_responder.sv
// Self-checking bench for axi_read_responder: directed corner bursts plus randomized bursts against a word-array reference model.
module tb_axi_read_responder;

    localparam int AW    = 26;
    localparam int DW    = 32;
    localparam int DL    = 10;
    localparam int WORDS = 1 << DL;
`ifdef AXI_RESP_INIT_LATENCY_EN
    localparam int ExpLatency = 5;
`else
    localparam int ExpLatency = 1;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] ARADDR;
    logic [3:0]    ARLEN;
    logic [3:0]    ARID;
    logic          ARVALID;
    logic          ARREADY;
    logic [DW-1:0] RDATA;
    logic [3:0]    RID;
    logic          RLAST;
    logic          RVALID;
    logic          RREADY;
    logic          wr_en;
    logic [DL-1:0] wr_addr;
    logic [DW-1:0] wr_data;

    logic [DW-1:0] refMem [WORDS];
    int            testsRun    = 0;
    int            testsFailed = 0;

    axi_read_responder dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ARADDR  (ARADDR),
        .ARLEN   (ARLEN),
        .ARID    (ARID),
        .ARVALID (ARVALID),
        .ARREADY (ARREADY),
        .RDATA   (RDATA),
        .RID     (RID),
        .RLAST   (RLAST),
        .RVALID  (RVALID),
        .RREADY  (RREADY),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        testsRun++;
        assert (observed === expected) else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Issues one read request and returns at the first falling edge with RVALID high (or after a bounded wait).
    task automatic applyStimulus(input logic [AW-1:0] addr, input logic [3:0] len, input logic [3:0] id,
                                 input bit holdAr, output int latency);
        int guard;
        ARADDR  = addr;
        ARLEN   = len;
        ARID    = id;
        ARVALID = 1'b1;
        guard   = 0;
        while (!ARREADY && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        @(negedge clk);
        if (!holdAr) ARVALID = 1'b0;
        latency = 1;
        while (!RVALID && latency < 40) begin
            @(negedge clk);
            latency++;
        end
    endtask

    // mode 0: RREADY always high, 1: repeating 1,0,0,1, 2: random.
    task automatic runBurst(input logic [AW-1:0] addr, input logic [3:0] len, input logic [3:0] id,
                            input int mode, input bit holdAr, input int abortBeat);
        int          n;
        int          idx0;
        int          k;
        int          step;
        int          lat;
        logic        rdy;
        logic [38:0] expBeat;
        logic [3:0]  pattern;
        pattern = 4'b1001;
        n       = (len == 4'd0) ? 16 : int'(len);
        idx0    = int'((addr >> 2) % WORDS);
        RREADY  = 1'b0;
        applyStimulus(addr, len, id, holdAr, lat);
        checkOutput("firstBeatLatency", 64'(lat), 64'(ExpLatency));
        k    = 0;
        step = 0;
        while (k < n && step < 200) begin
            expBeat = {1'b1, (k == n - 1), 1'b0, id, refMem[(idx0 + k) % WORDS]};
            checkOutput($sformatf("beat%0d", k), 64'({RVALID, RLAST, ARREADY, RID, RDATA}), 64'(expBeat));
            if (k == abortBeat) begin
                #2 rst_n = 1'b0;
                #1 checkOutput("asyncResetOutputs", 64'({ARREADY, RVALID, RLAST, RID, RDATA}), 64'(0));
                RREADY  = 1'b0;
                ARVALID = 1'b0;
                @(negedge clk);
                @(negedge clk);
                rst_n = 1'b1;
                @(negedge clk);
                checkOutput("arreadyAfterRelease", 64'(ARREADY), 64'(1));
                return;
            end
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = pattern[3 - (step % 4)];
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            RREADY = rdy;
            @(negedge clk);
            if (rdy) k++;
            step++;
        end
        checkOutput("beatsDelivered", 64'(k), 64'(n));
        checkOutput("idleAfterBurst", 64'({RVALID, RLAST, ARREADY}), 64'(3'b001));
        RREADY  = 1'b0;
        ARVALID = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] oldWord;
        logic [DW-1:0] newWord;
        int            lat;
        rst_n   = 1'b0;
        ARADDR  = '0;
        ARLEN   = 4'd0;
        ARID    = 4'd0;
        ARVALID = 1'b0;
        RREADY  = 1'b0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;

        // Reset state, then ARREADY on the first edge after release.
        repeat (2) @(negedge clk);
        checkOutput("resetOutputs", 64'({ARREADY, RVALID, RLAST, RID, RDATA}), 64'(0));

        // Fill the store while still in reset: contents must be kept across reset anyway.
        for (int i = 0; i < WORDS; i++) begin
            wr_en   = 1'b1;
            wr_addr = DL'(i);
            wr_data = (i < 8) ? DW'(32'h100 + i) : DW'($urandom());
            refMem[i] = wr_data;
            @(negedge clk);
        end
        wr_en = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("arreadyFirstEdge", 64'(ARREADY), 64'(1));

        runBurst(26'h0, 4'd8, 4'd3, 0, 1'b0, -1);
        runBurst(26'h0, 4'd8, 4'd3, 1, 1'b0, -1);
        runBurst(26'hFF8, 4'd4, 4'd9, 0, 1'b0, -1);
        runBurst(26'h3FF_F00B, 4'd0, 4'd12, 2, 1'b1, -1);
        runBurst(26'h0, 4'd8, 4'd6, 0, 1'b0, 2);
        runBurst(26'h123, 4'd2, 4'd1, 0, 1'b0, -1);

        // A backdoor write to the beat on display must not disturb it; the next word picks up its write.
        oldWord = refMem[16];
        RREADY  = 1'b0;
        applyStimulus(26'h40, 4'd3, 4'd5, 1'b0, lat);
        checkOutput("wrTestLatency", 64'(lat), 64'(ExpLatency));
        wr_en   = 1'b1;
        wr_addr = DL'(16);
        wr_data = 32'hDEAD_0016;
        refMem[16] = wr_data;
        @(negedge clk);
        newWord = 32'hBEEF_0017;
        wr_addr = DL'(17);
        wr_data = newWord;
        refMem[17] = wr_data;
        checkOutput("presentedBeatHeld1", 64'(RDATA), 64'(oldWord));
        @(negedge clk);
        wr_en  = 1'b0;
        RREADY = 1'b1;
        checkOutput("presentedBeatHeld2", 64'(RDATA), 64'(oldWord));
        @(negedge clk);
        checkOutput("freshWriteVisible", 64'(RDATA), 64'(newWord));
        @(negedge clk);
        checkOutput("wrTestLastBeat", 64'({RLAST, RDATA}), 64'({1'b1, refMem[18]}));
        @(negedge clk);
        RREADY = 1'b0;
        checkOutput("wrTestIdle", 64'({RVALID, ARREADY}), 64'(2'b01));

        for (int t = 0; t < 8; t++) begin
            runBurst(AW'($urandom()), 4'($urandom()), 4'($urandom()), 2, 1'b0, -1);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
